tail_light_controller: RTL and testbench
========================================

# tail_light_controller

Paced, arbitrated sequencer for the six-lamp rear cluster. It latches left-turn, right-turn and hazard requests, grants one at a time at step boundaries set by an internal prescaler, and drives the lamp pattern one step per tick. An optional brake overlay lights every lamp not owned by the active turn sequence. It sits between the driver-control inputs and the lamp drivers and replaces direct per-clock sequencing.

## Interface
- DIV, 4: clock cycles per sequence step; legal range ≥1; DIV=1 steps every cycle.
- CLOCK  input  1  system clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- L  input  1  left-turn request level.
- R  input  1  right-turn request level.
- H  input  1  hazard request level.
- BRAKE  input  1  brake pedal level.
- Lights  output  [1:6]  lamp drive; bit 1 = outermost left, bit 6 = outermost right.
- STEP  output  1  one-cycle pulse on every prescaler tick.
- BUSY  output  1  high whenever the state is not IDLE.

## Operation
- Prescaler:
  - Counter 0..DIV-1, free-running. Width is max(1, clog2(DIV)).
  - tick = (count == DIV-1); count wraps to 0 on tick.
- Pending register {pH, pL, pR}:
  - Each bit sets on any cycle its input is high.
  - Clear-and-set in the same cycle: set wins.
- FSM states and lamp patterns: IDLE 000000, L1 100000, L2 110000, L3 111000, R1 000001, R2 000011, R3 000111, LR3 111111. State advances only on tick.
- IDLE on tick:
  - pH, or pL and pR → LR3.
  - else pL → L1.
  - else pR → R1.
  - else stay in IDLE.
  - Leaving IDLE clears all pending bits.
- L1→L2→L3→IDLE and R1→R2→R3→IDLE, one step per tick. LR3→IDLE on tick.
- Hazard preemption: in L1, L2, R1 or R2, a tick with pH set → LR3 and clears pH. L3 and R3 are not preempted.
- Requests arriving mid-sequence stay pending and are arbitrated at the next IDLE tick.
- Brake mask (see Configuration):
  - IDLE → 111111.
  - L states → 000111.
  - R states → 111000.
  - LR3 → 000000.
- Lights register = pattern(next_state) | (BRAKE ? mask(next_state) : 0).
- RESET has priority over all other events:
  - state IDLE, count 0, pending 0.
  - Lights 000000, STEP 0, BUSY 0.

## Timing
- Reset values: Lights 000000, STEP 0, BUSY 0.
- First tick occurs on the DIV-th rising edge after RESET deasserts.
- Request to lamp latency: request is latched on the next edge and served at the first IDLE tick after it. A request high on a tick edge while in IDLE is served on that tick.
- State, Lights, STEP and BUSY all update on the same edge.
- BRAKE affects Lights on the next edge (one cycle), independent of ticks.
- A one-cycle pulse on L, R or H is never lost.
- A full turn sequence spans 3 ticks in lamp states, then returns to IDLE on the 4th.
- RESET mid-sequence: all outputs are at reset values on the next edge and the prescaler restarts from 0.

## Configuration
- Macro: TAIL_LIGHT_BRAKE_EN.
- Defined: brake overlay active as specified above.
- Undefined: mask is forced to 000000. The BRAKE port remains and is ignored. Lights = pattern(next_state) only.

## Structure
- Package tail_light_pkg holds:
  - the 6-bit state/pattern constants IDLE, L1–L3, R1–R3, LR3;
  - the brake mask constants;
  - the pending-bit index constants.
- Sub-module step_prescaler (parameter DIV; ports CLOCK, RESET, tick) generates tick. The FSM, pending register and output register live in tail_light_controller.

## Test plan
All scenarios use DIV=4.
- Reset, then L high for one cycle → Lights reads 100000, 110000, 111000, 000000 at 4-cycle intervals; BUSY is high for 12 cycles.
- L held, H pulsed during L2 → next tick 111111, following tick 000000; the L still held re-arbitrates at the next IDLE tick → 100000.
- L and R pulsed in the same cycle → next tick 111111; neither L1 nor R1 appears afterwards.
- R pulsed during an L sequence → L sequence completes, then R1 000001 appears at the tick after IDLE.
- With TAIL_LIGHT_BRAKE_EN, BRAKE high in IDLE → 111111 one cycle later; BRAKE during L1 → 100111. Without the macro, the same stimulus → 000000 and 100000.
- RESET asserted while in LR3 → 000000, STEP 0, BUSY 0 on the next edge; the first STEP pulse arrives 4 cycles after RESET deasserts.

Source files
------------

// File: rtl/tail_light_pkg.sv
// tail_light_pkg: lamp-pattern state encoding, brake masks and pending-bit indices for the tail-light sequencer.
package tail_light_pkg;
  typedef enum logic [5:0] {
    IDLE = 6'b000000,
    L1   = 6'b100000,
    L2   = 6'b110000,
    L3   = 6'b111000,
    R1   = 6'b000001,
    R2   = 6'b000011,
    R3   = 6'b000111,
    LR3  = 6'b111111
  } state_t;
  localparam logic [5:0] MASK_IDLE = 6'b111111;
  localparam logic [5:0] MASK_L    = 6'b000111;
  localparam logic [5:0] MASK_R    = 6'b111000;
  localparam logic [5:0] MASK_LR   = 6'b000000;
  localparam int PR = 0;
  localparam int PL = 1;
  localparam int PH = 2;
  function automatic logic [5:0] brake_mask(input state_t s);
    return s == IDLE ? MASK_IDLE :
           (s inside {L1, L2, L3}) ? MASK_L :
           (s inside {R1, R2, R3}) ? MASK_R : MASK_LR;
  endfunction
endpackage

// File: rtl/tail_light_controller_prescaler.sv
// step_prescaler: free-running 0..DIV-1 counter, tick on the last count.
module step_prescaler #(
  parameter int DIV = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] count;
  assign tick = count == W'(DIV - 1);
  always_ff @(posedge CLOCK)
    count <= (RESET || tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/tail_light_controller.sv
// tail_light_controller: paced, arbitrated L/R/hazard lamp sequencer; brake overlay enabled by TAIL_LIGHT_BRAKE_EN.
module tail_light_controller
  import tail_light_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       L,
  input  logic       R,
  input  logic       H,
  input  logic       BRAKE,
  output logic [1:6] Lights,
  output logic       STEP,
  output logic       BUSY
);
  state_t state, next;
  logic [2:0] pending, req, eff, pend_n;
  logic [5:0] mask;
  logic tick;
  step_prescaler #(.DIV(DIV)) u_prescaler (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .tick (tick)
  );
  assign req = {H, L, R};
  // a request arriving on the tick edge itself is arbitrated immediately
  assign eff = pending | req;
  always_comb begin
    next = state;
    pend_n = eff;
    if (tick) begin
      case (state)
        IDLE: begin
          next = (eff[PH] || (eff[PL] && eff[PR])) ? LR3 : eff[PL] ? L1 : eff[PR] ? R1 : IDLE;
          if (next != IDLE) pend_n = req;
        end
        L1: next = eff[PH] ? LR3 : L2;
        L2: next = eff[PH] ? LR3 : L3;
        R1: next = eff[PH] ? LR3 : R2;
        R2: next = eff[PH] ? LR3 : R3;
        default: next = IDLE;
      endcase
      if (state != IDLE && next == LR3) pend_n[PH] = H;
    end
  end
`ifdef TAIL_LIGHT_BRAKE_EN
  assign mask = BRAKE ? brake_mask(next) : '0;
`else
  logic unused_brake;
  assign unused_brake = BRAKE;
  assign mask = '0;
`endif
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      pending <= '0;
      Lights <= '0;
      STEP <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      state <= next;
      pending <= pend_n;
      Lights <= next | mask;
      STEP <= tick;
      BUSY <= next != IDLE;
    end
  end
endmodule

// File: tb/tb_tail_light_controller.sv
// tb_tail_light_controller: directed checks of sequencing, arbitration, preemption, brake overlay and reset (DIV=4).
module tb_tail_light_controller;
  logic CLOCK = 0, RESET = 1, L = 0, R = 0, H = 0, BRAKE = 0;
  logic [1:6] Lights;
  logic STEP, BUSY;
  int tests = 0, fails = 0;
  tail_light_controller #(.DIV(4)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .L     (L),
    .R     (R),
    .H     (H),
    .BRAKE (BRAKE),
    .Lights(Lights),
    .STEP  (STEP),
    .BUSY  (BUSY)
  );
  always #5 CLOCK = ~CLOCK;
  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask
  task automatic do_reset();
    RESET = 1; L = 0; R = 0; H = 0; BRAKE = 0;
    cyc(2);
    check("rst_lights", Lights, 6'b000000);
    check("rst_step", {5'b0, STEP}, 6'd0);
    check("rst_busy", {5'b0, BUSY}, 6'd0);
    RESET = 0;
  endtask
  initial begin
    // left pulse: full sequence, busy for 12 cycles
    do_reset();
    L = 1;
    cyc(1); L = 0;
    cyc(2); check("l_pre_tick_step", {5'b0, STEP}, 6'd0);
    cyc(1);
    check("l_l1", Lights, 6'b100000);
    check("l_step", {5'b0, STEP}, 6'd1);
    check("l_busy", {5'b0, BUSY}, 6'd1);
    cyc(1); check("l_step_pulse", {5'b0, STEP}, 6'd0);
    cyc(3); check("l_l2", Lights, 6'b110000);
    cyc(4); check("l_l3", Lights, 6'b111000);
    cyc(3); check("l_busy_end", {5'b0, BUSY}, 6'd1);
    cyc(1);
    check("l_idle", Lights, 6'b000000);
    check("l_idle_busy", {5'b0, BUSY}, 6'd0);
    // left held, hazard pulse during L2 preempts, then left re-arbitrates
    do_reset();
    L = 1;
    cyc(4); check("hz_l1", Lights, 6'b100000);
    cyc(4); check("hz_l2", Lights, 6'b110000);
    cyc(1); H = 1;
    cyc(1); H = 0;
    cyc(2); check("hz_lr3", Lights, 6'b111111);
    cyc(4); check("hz_idle", Lights, 6'b000000);
    cyc(4); check("hz_rearb_l1", Lights, 6'b100000);
    L = 0;
    // simultaneous left+right becomes hazard, neither served alone afterwards
    do_reset();
    L = 1; R = 1;
    cyc(1); L = 0; R = 0;
    cyc(3); check("lr_lr3", Lights, 6'b111111);
    cyc(4); check("lr_idle", Lights, 6'b000000);
    cyc(4); check("lr_idle2", Lights, 6'b000000);
    check("lr_busy", {5'b0, BUSY}, 6'd0);
    cyc(4); check("lr_idle3", Lights, 6'b000000);
    // right request mid left sequence stays pending
    do_reset();
    L = 1;
    cyc(1); L = 0;
    cyc(3); check("rl_l1", Lights, 6'b100000);
    cyc(1); R = 1;
    cyc(1); R = 0;
    cyc(6); check("rl_l3", Lights, 6'b111000);
    cyc(4); check("rl_idle", Lights, 6'b000000);
    cyc(4); check("rl_r1", Lights, 6'b000001);
    cyc(4); check("rl_r2", Lights, 6'b000011);
    cyc(4); check("rl_r3", Lights, 6'b000111);
    // brake overlay
    do_reset();
    BRAKE = 1;
    cyc(1);
`ifdef TAIL_LIGHT_BRAKE_EN
    check("brk_idle", Lights, 6'b111111);
`else
    check("brk_idle", Lights, 6'b000000);
`endif
    BRAKE = 0; L = 1;
    cyc(1); check("brk_off", Lights, 6'b000000);
    L = 0;
    cyc(2); check("brk_l1", Lights, 6'b100000);
    cyc(1); BRAKE = 1;
    cyc(1);
`ifdef TAIL_LIGHT_BRAKE_EN
    check("brk_l1_on", Lights, 6'b100111);
`else
    check("brk_l1_on", Lights, 6'b100000);
`endif
    BRAKE = 0;
    // reset while in hazard state, prescaler restarts
    do_reset();
    H = 1;
    cyc(1); H = 0;
    cyc(3); check("rs_lr3", Lights, 6'b111111);
    cyc(1); RESET = 1;
    cyc(1);
    check("rs_lights", Lights, 6'b000000);
    check("rs_step", {5'b0, STEP}, 6'd0);
    check("rs_busy", {5'b0, BUSY}, 6'd0);
    RESET = 0;
    cyc(3); check("rs_no_step3", {5'b0, STEP}, 6'd0);
    cyc(1); check("rs_step4", {5'b0, STEP}, 6'd1);
    check("rs_idle_after", Lights, 6'b000000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
